// File: rtl/softmax_seq_pkg.sv
// Shared types, sizes and helpers for the softmax sequencer.
// SOFTMAX_MAX_SUB_EN adds the max-subtraction pass (MAX state) ahead of the exp pass.
package softmax_seq_pkg;

    localparam int N_CLASS   = 5;
    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 10;
    localparam int ADDR_W    = 10;
    localparam int SUM_SHIFT = 6;
    localparam int OUT_SHIFT = 10;
    localparam int SUM_W     = DATA_W + $clog2(N_CLASS);

`ifdef SOFTMAX_MAX_SUB_EN
    localparam int LATENCY = 3*N_CLASS + 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_EXP,
        S_INV,
        S_MUL,
        S_OUT
    } state_t;
`else
    localparam int LATENCY = 2*N_CLASS + 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXP,
        S_INV,
        S_MUL,
        S_OUT
    } state_t;
`endif

    typedef logic signed [DATA_W-1:0]   logit_t;
    typedef logic        [DATA_W-1:0]   exp_t;
    typedef logic        [SUM_W-1:0]    sum_t;
    typedef logic        [2*DATA_W-1:0] prod_t;

    // Scale a full product down and clamp to the unsigned output range.
    function automatic exp_t sat_u(input prod_t p);
        prod_t s;
        s = p >> OUT_SHIFT;
        if (|s[2*DATA_W-1:DATA_W])
            return '1;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] inv_index(input sum_t s);
        sum_t q;
        q = s >> SUM_SHIFT;
        if (|q[SUM_W-1:ADDR_W])
            return '1;
        return q[ADDR_W-1:0];
    endfunction

    // Integer part of a widened fixed-point value; negatives wrap into the upper table half.
    function automatic logic [ADDR_W-1:0] exp_index(input logic signed [DATA_W:0] v);
        return ADDR_W'(v >>> FRAC_W);
    endfunction

endpackage

// File: rtl/softmax_rom_1024.sv
// 1024-entry table with registered single-port read (1-cycle latency).
// The write strobe shares the address port and is used to load table contents.
module softmax_rom_1024
    import softmax_seq_pkg::*;
#(
    parameter int RDATA_W = DATA_W,
    parameter int RADDR_W = ADDR_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [RADDR_W-1:0] addr,
    input  logic [RDATA_W-1:0] wdata,
    output logic [RDATA_W-1:0] data
);

    logic [RDATA_W-1:0] mem [2**RADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else
            data <= mem[addr];
    end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: exp lookups with sum, one reciprocal lookup, then shared-multiplier scaling.
// Define SOFTMAX_MAX_SUB_EN to subtract the maximum logit before the exp lookups.
//
// state  | meaning
// IDLE   | ready for a logit vector
// MAX    | (SOFTMAX_MAX_SUB_EN) scan logits for the signed maximum
// EXP    | one exp lookup per cycle, N_CLASS+1 cycles to catch the last datum
// INV    | reciprocal lookup of the scaled sum, 2 cycles
// MUL    | one output element per cycle through the shared multiplier
// OUT    | hold result until out_ready
module softmax_seq_ctrl
    import softmax_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CLASS*DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0]         exp_rom_addr,
    input  logic [DATA_W-1:0]         exp_rom_data,
    output logic [ADDR_W-1:0]         inv_rom_addr,
    input  logic [DATA_W-1:0]         inv_rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CLASS*DATA_W-1:0] out_data,
    output logic                      busy
);

    localparam logic [2:0] K_LAST    = 3'(N_CLASS - 1);
    localparam logic [2:0] K_EXP_END = 3'(N_CLASS);
    localparam logic [2:0] K_INV_END = 3'd1;

`ifdef SOFTMAX_MAX_SUB_EN
    localparam state_t FIRST_STATE = S_MAX;
`else
    localparam state_t FIRST_STATE = S_EXP;
`endif

    state_t state, state_d;
    logic [2:0] k, k_d, k_nxt;

    logit_t logit_q [N_CLASS];
    exp_t   exp_q   [N_CLASS];
    sum_t   sum_q, sum_add;
    exp_t   inv_q;
    prod_t  prod;
    logic   accept;

    logic [ADDR_W-1:0]         exp_addr_q, inv_addr_q;
    logic [ADDR_W-1:0]         first_idx, next_idx;
    logic [N_CLASS*DATA_W-1:0] out_q;

    function automatic logic signed [DATA_W:0] widen(input logit_t a);
        return {a[DATA_W-1], a};
    endfunction

    assign accept  = in_valid && (state == S_IDLE);
    assign k_nxt   = k + 3'd1;
    assign sum_add = sum_q + {{(SUM_W-DATA_W){1'b0}}, exp_rom_data};
    assign prod    = {{DATA_W{1'b0}}, exp_q[k]} * {{DATA_W{1'b0}}, inv_q};

`ifdef SOFTMAX_MAX_SUB_EN
    logit_t max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (k == 3'd0)
            max_d = logit_q[0];
        else if (logit_q[k] > max_q)
            max_d = logit_q[k];
    end

    // Differences are never positive, so the max element always lands on index 0.
    assign first_idx = exp_index(widen(logit_q[0]) - widen(max_d));
    assign next_idx  = exp_index(widen(logit_q[k_nxt]) - widen(max_q));
`else
    assign first_idx = exp_index(widen(logit_t'(in_data[DATA_W-1:0])));
    assign next_idx  = exp_index(widen(logit_q[k_nxt]));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
        end else begin
            state <= state_d;
            k     <= k_d;
        end
    end

    always_comb begin
        state_d   = state;
        k_d       = k;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = FIRST_STATE;
                    k_d     = '0;
                end
            end
`ifdef SOFTMAX_MAX_SUB_EN
            S_MAX: begin
                if (k == K_LAST) begin
                    state_d = S_EXP;
                    k_d     = '0;
                end else begin
                    k_d = k_nxt;
                end
            end
`endif
            S_EXP: begin
                if (k == K_EXP_END) begin
                    state_d = S_INV;
                    k_d     = '0;
                end else begin
                    k_d = k_nxt;
                end
            end
            S_INV: begin
                if (k == K_INV_END) begin
                    state_d = S_MUL;
                    k_d     = '0;
                end else begin
                    k_d = k_nxt;
                end
            end
            S_MUL: begin
                if (k == K_LAST) begin
                    state_d = S_OUT;
                    k_d     = '0;
                end else begin
                    k_d = k_nxt;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are registered one cycle ahead so the ROM sees them at the start of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CLASS; i++) begin
                logit_q[i] <= '0;
                exp_q[i]   <= '0;
            end
            sum_q      <= '0;
            inv_q      <= '0;
            exp_addr_q <= '0;
            inv_addr_q <= '0;
            out_q      <= '0;
`ifdef SOFTMAX_MAX_SUB_EN
            max_q      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < N_CLASS; i++)
                            logit_q[i] <= in_data[i*DATA_W +: DATA_W];
                        sum_q <= '0;
`ifndef SOFTMAX_MAX_SUB_EN
                        exp_addr_q <= first_idx;
`endif
                    end
                end
`ifdef SOFTMAX_MAX_SUB_EN
                S_MAX: begin
                    max_q <= max_d;
                    if (k == K_LAST)
                        exp_addr_q <= first_idx;
                end
`endif
                S_EXP: begin
                    if (k < K_LAST)
                        exp_addr_q <= next_idx;
                    if (k != 3'd0) begin
                        exp_q[k - 3'd1] <= exp_rom_data;
                        sum_q           <= sum_add;
                    end
                    if (k == K_EXP_END)
                        inv_addr_q <= inv_index(sum_add);
                end
                S_INV: begin
                    if (k == K_INV_END)
                        inv_q <= inv_rom_data;
                end
                S_MUL: begin
                    out_q[k*DATA_W +: DATA_W] <= sat_u(prod);
                end
                default: ;
            endcase
        end
    end

    assign exp_rom_addr = exp_addr_q;
    assign inv_rom_addr = inv_addr_q;
    assign out_data     = out_q;

endmodule
